ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch stage for the pipelined CPU. It owns the architectural fetch PC and issues one-outstanding requests to a variable-latency instruction memory. Returned instructions are buffered with their PCs in a small FIFO, which feeds the IF/ID pipeline register through a valid/ready handshake. A redirect input from the branch-resolution logic flushes the queue and any in-flight fetch.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 64'd0, fetch address after reset; bits [1:0] must be 0

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low; the block is in reset while low at posedge clk
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  64  fetch address; stable while imem_req=1
- imem_ack  in  1  response valid; only meaningful while imem_req=1
- imem_rdata  in  32  instruction word, sampled when imem_ack=1
- out_valid  out  1  queue head valid
- out_instr  out  32  head instruction
- out_pc  out  64  head PC
- out_ready  in  1  consumer accepts head; pop = out_valid & out_ready
- redirect  in  1  flush and restart fetch
- redirect_pc  in  64  new fetch PC; bits [1:0] forced to 0
- perf_fetched  out  32  present only with IFETCH_PERF_EN
- perf_flushed  out  32  present only with IFETCH_PERF_EN

## Operation
- State: fetch_pc (64), count (0..DEPTH), rd/wr pointers (log2 DEPTH, wrap modulo DEPTH), FSM {IDLE, BUSY, DROP}.
- imem_req = (state != IDLE). imem_addr = fetch_pc in BUSY, drop_addr in DROP.
- IDLE → BUSY when count < DEPTH, with no redirect.
- BUSY, on imem_ack without redirect:
  - push {imem_rdata, fetch_pc}
  - fetch_pc += 4, wrapping at 2^64
  - stay BUSY if the next count < DEPTH; otherwise go IDLE.
- BUSY, without ack: hold imem_req and imem_addr.
- Redirect has priority over push and pop in the same cycle:
  - count ← 0, pointers ← 0, fetch_pc ← {redirect_pc[63:2], 2'b00}.
  - In IDLE, or in BUSY with imem_ack the same cycle: the response is discarded and the next state is BUSY.
  - In BUSY without ack: drop_addr ← the old fetch_pc, next state DROP.
- DROP:
  - Keep requesting drop_addr until imem_ack, then discard the data and go BUSY.
  - A redirect in DROP only updates fetch_pc.
- Pop with no push: count −1. Push and pop together: count unchanged. A push never happens at count == DEPTH.
- out_instr and out_pc always reflect the head entry. Their value is don't-care when out_valid=0, except 0 after reset.

## Timing
- All registers reset when reset=0 at posedge clk. The first cycle after reset has state IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, out_valid=0, out_instr=0, out_pc=0, perf counters=0.
- Reset while a request is outstanding: the request is abandoned and imem_req=0 on the next cycle. The memory must ignore the abandoned request.
- Request issue:
  - Reset release at cycle N (first cycle with reset=1): imem_req=1 with RESET_PC at N+1.
  - Redirect at cycle N with nothing outstanding: imem_req=1 with the new PC at N+1.
- Ack-to-output latency is 1 cycle. imem_ack at cycle M gives out_valid=1 at M+1 if the queue was empty.
- Back-to-back: a request may be acked in the same cycle it is first asserted. The peak rate is one instruction per cycle.
- Redirect at cycle N gives out_valid=0 at N+1. No pre-redirect instruction is ever presented after N.

## Configuration
- IFETCH_PERF_EN defined:
  - perf_fetched increments on each push.
  - perf_flushed increments by the count being discarded on each redirect, plus 1 if a response is discarded (the in-flight DROP response or the same-cycle ack).
  - Both counters wrap at 2^32 and reset to 0.
- IFETCH_PERF_EN undefined: the counters and both ports are absent, and behaviour is otherwise identical.

## Test plan
- Reset and stream: RESET_PC=0, imem_ack=1 every cycle, out_ready=1 → out_pc sequence 0,4,8,12 on consecutive cycles, first valid 2 cycles after reset release.
- Fill and backpressure: out_ready=0, ack every cycle → exactly 4 pushes (DEPTH=4), then imem_req=0. Raising out_ready for 1 cycle → one new request and the head pops.
- Redirect while waiting: request to addr 0x10 outstanding, redirect_pc=0x200 → imem_addr stays 0x10 until ack; that data is discarded; next request is 0x200; out_pc=0x200 is the first valid entry.
- Redirect same cycle as ack and pop, with 3 entries queued → out_valid=0 next cycle, the acked word is dropped, the next request is redirect_pc. With IFETCH_PERF_EN, perf_flushed increases by 4.
- PC wrap: redirect_pc=64'hFFFF_FFFF_FFFF_FFFC, two acks → out_pc FFFF_FFFF_FFFF_FFFC then 0. redirect_pc=0x103 → fetch at 0x100.
- Mid-operation reset: reset=0 while imem_req=1 with 2 entries queued → next cycle imem_req=0, out_valid=0, fetch_pc=RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch stage with a PC-tagged fetch queue
//
// Purpose:
//   Owns the architectural fetch PC and issues one-outstanding requests to a
//   variable-latency instruction memory. Returned words are buffered together
//   with their PCs in a DEPTH-entry FIFO that feeds the IF/ID register through
//   a valid/ready handshake. A redirect flushes the queue and any in-flight
//   fetch and restarts fetching at the new PC.
//
// Parameters:
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  fetch address after reset (bits [1:0] zero)
//
// Ports:
//   clk           clock, all state updates on posedge
//   reset         synchronous active-low reset
//   imem_req      fetch request, held until imem_ack
//   imem_addr     fetch address, stable while imem_req=1
//   imem_ack      response valid (ignored while imem_req=0)
//   imem_rdata    instruction word, sampled on imem_ack
//   out_valid     queue head valid
//   out_instr     head instruction
//   out_pc        head PC
//   out_ready     consumer accepts the head
//   redirect      flush and restart fetch
//   redirect_pc   new fetch PC (bits [1:0] forced to zero)
//   perf_fetched  pushes into the queue       (IFETCH_PERF_EN only)
//   perf_flushed  entries/responses discarded (IFETCH_PERF_EN only)
//
// Build option:
//   IFETCH_PERF_EN  adds the two 32-bit performance counters and their ports.

module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [63:0]     r_fetch_pc;
  logic [63:0]     r_drop_addr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [31:0]     r_instr_q [DEPTH];
  logic [63:0]     r_pc_q    [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_has_room;
  logic [CW-1:0]   w_count_next;
  logic [63:0]     w_redirect_pc;
  logic            w_unused_bits;

  // Low address bits of a redirect target are ignored: fetch is word aligned.
  assign w_redirect_pc = {redirect_pc[63:2], 2'b00};
  assign w_unused_bits = ^redirect_pc[1:0];

  assign w_has_room = (r_count < CW'(DEPTH));

  // Redirect outranks both queue operations: the flush wins and the consumer's
  // handshake in that cycle is not honoured, so no stale entry is ever popped.
  assign w_push = (r_state == S_BUSY) && imem_ack && !redirect;
  assign w_pop  = out_valid && out_ready && !redirect;

  always_comb begin
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (redirect || w_has_room) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (redirect) begin
          // An unanswered request cannot be withdrawn; its response must be
          // absorbed in DROP before the redirected fetch can go out.
          w_state_next = imem_ack ? S_BUSY : S_DROP;
        end else if (imem_ack) begin
          w_state_next = (w_count_next < CW'(DEPTH)) ? S_BUSY : S_IDLE;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          w_state_next = S_BUSY;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req  = (r_state != S_IDLE);
    imem_addr = (r_state == S_DROP) ? r_drop_addr : r_fetch_pc;
    out_valid = (r_count != '0);
    out_instr = r_instr_q[r_rd_ptr];
    out_pc    = r_pc_q[r_rd_ptr];
  end

  // ---------------------------------------------------------------------------
  // Fetch PC, queue storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      // Storage is cleared so the head outputs read zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= 32'd0;
        r_pc_q[i]    <= 64'd0;
      end
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_fetch_pc <= w_redirect_pc;
        // Remember the abandoned address so imem_addr stays stable until the
        // memory answers it.
        if ((r_state == S_BUSY) && !imem_ack) begin
          r_drop_addr <= r_fetch_pc;
        end
      end else begin
        if (w_push) begin
          r_instr_q[r_wr_ptr] <= imem_rdata;
          r_pc_q[r_wr_ptr]    <= r_fetch_pc;
          r_wr_ptr            <= r_wr_ptr + PW'(1);
          r_fetch_pc          <= r_fetch_pc + 64'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
    end
  end

`ifdef IFETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic        w_resp_discard;
  logic [31:0] w_flush_inc;

  // A response is thrown away either when it lands together with a redirect,
  // or when it is the answer to a request abandoned by an earlier redirect.
  assign w_resp_discard = imem_ack &&
                          (((r_state == S_BUSY) && redirect) || (r_state == S_DROP));

  always_comb begin
    w_flush_inc = {31'd0, w_resp_discard};
    if (redirect) begin
      w_flush_inc = w_flush_inc + 32'(r_count);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched <= 32'd0;
      perf_flushed <= 32'd0;
    end else begin
      if (w_push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      perf_flushed <= perf_flushed + w_flush_inc;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue

module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  // Advance to just after the next rising edge; outputs then show this cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Answer the current request (if any) when ack_en is set.
  task automatic drive_mem(input bit ack_en);
    imem_ack   = ack_en && imem_req;
    imem_rdata = ack_en ? mem_word(imem_addr) : 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
    out_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
    checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_fetched, perf_flushed);
    end
`endif
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    do_reset();
    reset = 1'b1; out_ready = 1'b1; drive_mem(1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_n_valid: got %b expected 0", out_valid); end
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_n1_valid: got %b expected 0", out_valid); end
    drive_mem(1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive_mem(1'b1);
      exp_pc = RESET_PC + 64'(4 * i);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL stream_seq%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_fill();
    int pushes;
    int reqs;
    do_reset();
    reset = 1'b1; out_ready = 1'b0;
    pushes = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      drive_mem(1'b1);
      if (imem_ack) pushes++;
    end
    checks++; if (pushes != DEPTH) begin errors++; $display("FAIL fill_pushes: got %0d expected %0d", pushes, DEPTH); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req_idle: got %b expected 0", imem_req); end
    checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
      errors++; $display("FAIL fill_head: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, RESET_PC);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    drive_mem(1'b1);
    reqs = imem_req ? 1 : 0;
    checks++; if (out_pc !== RESET_PC + 64'd4) begin
      errors++; $display("FAIL fill_pop_head: got %h expected %h", out_pc, RESET_PC + 64'd4);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      drive_mem(1'b1);
      if (imem_req) reqs++;
    end
    checks++; if (reqs != 1) begin errors++; $display("FAIL fill_refill_reqs: got %0d expected 1", reqs); end
    checks++; if (out_valid !== 1'b1 || out_pc !== RESET_PC + 64'd4 || imem_req !== 1'b0) begin
      errors++; $display("FAIL fill_after: got v=%b pc=%h req=%b expected v=1 pc=%h req=0",
                         out_valid, out_pc, imem_req, RESET_PC + 64'd4);
    end
  endtask

  task automatic test_redirect_wait();
    bit found;
    do_reset();
    reset = 1'b1; out_ready = 1'b1; drive_mem(1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (imem_req && imem_addr == 64'h10) found = 1'b1;
      else drive_mem(1'b1);
    end
    checks++; if (!found) begin errors++; $display("FAIL rw_reach_0x10: got none expected request to 0x10"); end
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 64'h200;
    cyc();
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_flush_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h10) begin
        errors++; $display("FAIL rw_hold%0d: got req=%b addr=%h expected req=1 addr=10", i, imem_req, imem_addr);
      end
      if (i < 3) cyc();
    end
    drive_mem(1'b1);
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h200 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rw_next_req: got req=%b addr=%h v=%b expected req=1 addr=200 v=0", imem_req, imem_addr, out_valid);
    end
    drive_mem(1'b1);
    out_ready = 1'b0;
    cyc();
    drive_mem(1'b0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h200 || out_instr !== mem_word(64'h200)) begin
      errors++; $display("FAIL rw_first_entry: got v=%b pc=%h instr=%h expected v=1 pc=200 instr=%h",
                         out_valid, out_pc, out_instr, mem_word(64'h200));
    end
  endtask

  task automatic test_redirect_ack_pop();
    int pushes;
    bit found;
`ifdef IFETCH_PERF_EN
    logic [31:0] flushed_before;
`endif
    do_reset();
    reset = 1'b1; out_ready = 1'b0;
    pushes = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (imem_req && pushes == 3) found = 1'b1;
      else begin
        drive_mem(1'b1);
        if (imem_ack) pushes++;
      end
    end
    checks++; if (!found || out_valid !== 1'b1) begin
      errors++; $display("FAIL rap_setup: got found=%b v=%b expected found=1 v=1", found, out_valid);
    end
`ifdef IFETCH_PERF_EN
    flushed_before = perf_flushed;
`endif
    drive_mem(1'b1);
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h400;
    cyc();
    redirect = 1'b0; out_ready = 1'b0; imem_ack = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rap_valid: got %b expected 0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h400) begin
      errors++; $display("FAIL rap_next_req: got req=%b addr=%h expected req=1 addr=400", imem_req, imem_addr);
    end
`ifdef IFETCH_PERF_EN
    checks++; if (perf_flushed - flushed_before !== 32'd4) begin
      errors++; $display("FAIL rap_perf_flushed: got +%0d expected +4", perf_flushed - flushed_before);
    end
`endif
    drive_mem(1'b1);
    cyc();
    drive_mem(1'b0);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h400) begin
      errors++; $display("FAIL rap_entry: got v=%b pc=%h expected v=1 pc=400", out_valid, out_pc);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    reset = 1'b1; out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_req: got req=%b addr=%h expected req=1 addr=fffffffffffffffc", imem_req, imem_addr);
    end
    drive_mem(1'b1);
    cyc();
    drive_mem(1'b1);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_pc0: got v=%b pc=%h expected v=1 pc=fffffffffffffffc", out_valid, out_pc);
    end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'd0 || out_instr !== mem_word(64'd0)) begin
      errors++; $display("FAIL wrap_pc1: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=%h",
                         out_valid, out_pc, out_instr, mem_word(64'd0));
    end
    drive_mem(1'b1);
    redirect = 1'b1; redirect_pc = 64'h103;
    cyc();
    redirect = 1'b0; imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h100 || out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_align: got req=%b addr=%h v=%b expected req=1 addr=100 v=0", imem_req, imem_addr, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int pushes;
    bit found;
    do_reset();
    reset = 1'b1; out_ready = 1'b0;
    pushes = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (imem_req && pushes == 2) found = 1'b1;
      else begin
        drive_mem(1'b1);
        if (imem_ack) pushes++;
      end
    end
    imem_ack = 1'b0;
    checks++; if (!found || out_valid !== 1'b1) begin
      errors++; $display("FAIL mr_setup: got found=%b v=%b expected found=1 v=1", found, out_valid);
    end
    reset = 1'b0;
    cyc();
    checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mr_abandon: got req=%b v=%b expected req=0 v=0", imem_req, out_valid);
    end
    reset = 1'b1;
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC || out_valid !== 1'b0) begin
      errors++; $display("FAIL mr_restart: got req=%b addr=%h v=%b expected req=1 addr=%h v=0",
                         imem_req, imem_addr, out_valid, RESET_PC);
    end
  endtask

  // Random traffic checked against a transaction-level model: a queue of the
  // PCs that should be buffered, the next PC the fetcher should ask for, and
  // whether the next response belongs to an abandoned request.
  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] exp_fetch;
    bit          drop_pending;
    bit          prev_stall;
    logic [63:0] prev_addr;
    bit          pop;
    int          fetched;
    int          flushed;
    do_reset();
    reset = 1'b1;
    q.delete();
    exp_fetch = RESET_PC; drop_pending = 1'b0; prev_stall = 1'b0; prev_addr = 64'd0;
    fetched = 0; flushed = 0;
    for (int c = 0; c < 800; c++) begin
      cyc();
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, out_valid, q.size() != 0);
      end else if (out_valid && (out_pc !== q[0] || out_instr !== mem_word(q[0]))) begin
        errors++; $display("FAIL rnd_head c%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                           c, out_pc, out_instr, q[0], mem_word(q[0]));
      end
      if (prev_stall) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          errors++; $display("FAIL rnd_hold c%0d: got req=%b addr=%h expected req=1 addr=%h", c, imem_req, imem_addr, prev_addr);
        end
      end
      out_ready = ($urandom_range(2) != 0);
      redirect  = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else redirect_pc = {$urandom, $urandom};
      drive_mem($urandom_range(3) != 0);
      prev_stall = imem_req && !imem_ack;
      prev_addr  = imem_addr;
      pop = out_valid && out_ready && !redirect;
      if (redirect) begin
        flushed += q.size() + ((imem_req && imem_ack) ? 1 : 0);
        q.delete();
        drop_pending = imem_req && !imem_ack;
        exp_fetch = {redirect_pc[63:2], 2'b00};
      end else begin
        if (pop) void'(q.pop_front());
        if (imem_req && imem_ack) begin
          if (drop_pending) begin
            drop_pending = 1'b0;
            flushed++;
          end else begin
            checks++;
            if (imem_addr !== exp_fetch) begin
              errors++; $display("FAIL rnd_fetch_addr c%0d: got %h expected %h", c, imem_addr, exp_fetch);
            end
            q.push_back(exp_fetch);
            exp_fetch += 64'd4;
            fetched++;
            checks++;
            if (q.size() > DEPTH) begin
              errors++; $display("FAIL rnd_overflow c%0d: got %0d entries expected <= %0d", c, q.size(), DEPTH);
            end
          end
        end
      end
    end
    cyc();
    redirect = 1'b0; imem_ack = 1'b0;
`ifdef IFETCH_PERF_EN
    checks++; if (perf_fetched !== 32'(fetched) || perf_flushed !== 32'(flushed)) begin
      errors++; $display("FAIL rnd_perf: got %0d/%0d expected %0d/%0d", perf_fetched, perf_flushed, fetched, flushed);
    end
`endif
    checks++; if (fetched < 50) begin
      errors++; $display("FAIL rnd_progress: got %0d fetches expected >= 50", fetched);
    end
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
    out_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
